// File: rtl/mem_wait_responder_if.sv
// Request/response bus between the multicycle datapath (master) and the
// word memory responder (slave).
//   mem_read, mem_write : request levels from the initiator
//   addr, wdata         : byte address and write data from the initiator
//   rdata               : last completed read value
//   ready               : one-cycle completion pulse
//   busy                : access in progress
//   addr_err            : request rejected, coincident with ready
interface mem_wait_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        addr_err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, busy, addr_err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, busy, addr_err
  );
endinterface

// File: rtl/mem_wait_responder.sv
// Word-organised memory responder with fixed, programmable read/write wait
// states. Each accepted request ends with a one-cycle ready pulse; rejected
// requests (both ops, misaligned, out of range) finish one cycle after
// acceptance with addr_err set and touch neither storage nor rdata.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset (memory contents are kept)
//   bus : slave side of mem_wait_responder_if (request in, response out)
module mem_wait_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned READ_LAT    = 2,
  parameter int unsigned WRITE_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_wait_responder_if.slave   bus
);

  localparam int unsigned AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned MaxLat = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

  typedef enum logic [1:0] {StIdle, StRwait, StWwait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mem_we;

  logic [31:0] mem [DEPTH_WORDS];

  logic req_both, req_misaligned, req_oor;

  // Range check uses the full word address so high bits never alias.
  always_comb begin
    req_both       = bus.mem_read & bus.mem_write;
    req_misaligned = (bus.addr[1:0] != 2'b00);
    req_oor        = ({2'b00, bus.addr[31:2]} >= DEPTH_WORDS);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.mem_read || bus.mem_write) begin
          idx_d   = bus.addr[AW+1:2];
          wdata_d = bus.wdata;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (req_both || req_misaligned || req_oor) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (bus.mem_read) begin
            cnt_d   = CntW'(READ_LAT - 1);
            state_d = StRwait;
          end else begin
            cnt_d   = CntW'(WRITE_LAT - 1);
            state_d = StWwait;
          end
        end
      end
      StRwait: begin
        if (cnt_q == '0) begin
          rdata_d = mem[idx_q];
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWwait: begin
        if (cnt_q == '0) begin
          mem_we  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; a reset at the commit edge aborts the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ready    = (state_q == StDone);
  assign bus.busy     = (state_q == StRwait) || (state_q == StWwait);
  assign bus.addr_err = (state_q == StDone) && err_q;

endmodule
